// File: rtl/letc_core_axi_fsm_pkg.sv
// letc_core_axi_fsm shared types
// LIMP sizes, AXI response codes, FSM states
package letc_core_axi_fsm_pkg;

  localparam int PADDR_WIDTH = 32;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } limp_size_e;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE
  } axi_fsm_state_e;

  function automatic logic misaligned(
    input limp_size_e size,
    input logic [1:0] lo
  );
    return ((size == SIZE_HALF) && lo[0])
        || ((size == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/letc_core_axi_fsm_if.sv
// LIMP memory-request interface
// requestor drives the request, servicer answers
interface letc_core_limp_if;
  import letc_core_axi_fsm_pkg::*;

  logic                   valid;
  logic                   wen_nren;
  limp_size_e             size;
  logic [PADDR_WIDTH-1:0] addr;
  logic [31:0]            wdata;
  logic                   ready;
  logic [31:0]            rdata;

  modport requestor (
    output valid, wen_nren, size, addr, wdata,
    input  ready, rdata
  );

  modport servicer (
    input  valid, wen_nren, size, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/letc_core_lane_align.sv
// Byte-lane strobe, read extraction, write replication
// Purely combinational; shared with the caches
module letc_core_lane_align
  import letc_core_axi_fsm_pkg::*;
(
  input  limp_size_e  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wword,
  output logic [3:0]  strb,
  output logic [31:0] rdata,
  output logic [31:0] wdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Decode lanes from size and low address bits
  always_comb begin
    strb  = 4'hF;
    rdata = rword;
    wdata = wword;
    unique case (1'b1)
      (size == SIZE_BYTE): begin
        strb  = 4'b0001 << addr_lo;
        rdata = {24'h0, rbyte};
        wdata = {4{wword[7:0]}};
      end
      (size == SIZE_HALF): begin
        strb  = 4'b0011 << {addr_lo[1], 1'b0};
        rdata = {16'h0, rhalf};
        wdata = {2{wword[15:0]}};
      end
      default: begin
        strb  = 4'hF;
        rdata = rword;
        wdata = wword;
      end
    endcase
  end

endmodule

// File: rtl/letc_core_axi_fsm.sv
// LIMP to AXI4 single-beat bridge
// One outstanding transaction, ready pulse on completion
module letc_core_axi_fsm
  import letc_core_axi_fsm_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 4,
  parameter int AXI_ID       = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  letc_core_limp_if.servicer      limp,
  output logic                    o_bus_error,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [PADDR_WIDTH-1:0]  o_araddr,
  output logic [AXI_ID_WIDTH-1:0] o_arid,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [31:0]             i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic [AXI_ID_WIDTH-1:0] i_rid,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [PADDR_WIDTH-1:0]  o_awaddr,
  output logic [AXI_ID_WIDTH-1:0] o_awid,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [31:0]             o_wdata,
  output logic [3:0]              o_wstrb,
  output logic                    o_wlast,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  input  logic [AXI_ID_WIDTH-1:0] i_bid
);

  axi_fsm_state_e state_q, state_d;

  logic [PADDR_WIDTH-1:0] addr_q;
  limp_size_e             size_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  axi_resp_e              resp_q;
  logic                   aw_done_q;
  logic                   w_done_q;

  logic        aw_fire;
  logic        w_fire;
  logic        accept;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;

  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(AXI_ID);

  assign accept  = (state_q == ST_IDLE) && limp.valid;
  assign aw_fire = o_awvalid && i_awready;
  assign w_fire  = o_wvalid && i_wready;

  letc_core_lane_align u_align (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .rword   (rdata_q),
    .wword   (wdata_q),
    .strb    (strb),
    .rdata   (limp.rdata),
    .wdata   (wdata_rep)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (limp.valid)
          state_d = limp.wen_nren ? ST_WR_REQ : ST_RD_ADDR;
      end
      ST_RD_ADDR: if (i_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (i_rvalid)  state_d = ST_DONE;
      ST_WR_REQ: begin
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire))
          state_d = ST_WR_RESP;
      end
      ST_WR_RESP: if (i_bvalid) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= AXI_OKAY;
    end else begin
      if (accept) begin
        addr_q  <= limp.addr;
        size_q  <= limp.size;
        wdata_q <= limp.wdata;
      end
      if ((state_q == ST_RD_DATA) && i_rvalid) begin
        rdata_q <= i_rdata;
        resp_q  <= axi_resp_e'(i_rresp);
      end
      if ((state_q == ST_WR_RESP) && i_bvalid)
        resp_q <= axi_resp_e'(i_bresp);
    end
  end

  // Per-channel completion for the write request phase
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || (state_q != ST_WR_REQ)) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
    end
  end

  assign o_arvalid = (state_q == ST_RD_ADDR);
  assign o_araddr  = {addr_q[PADDR_WIDTH-1:2], 2'b00};
  assign o_arid    = ID;
  assign o_arlen   = 8'd0;
  assign o_arsize  = 3'b010;
  assign o_arburst = AXI_BURST_INCR;
  assign o_rready  = (state_q == ST_RD_DATA);

  assign o_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
  assign o_awaddr  = addr_q;
  assign o_awid    = ID;
  assign o_awlen   = 8'd0;
  assign o_awsize  = {1'b0, size_q};
  assign o_awburst = AXI_BURST_INCR;

  assign o_wvalid = (state_q == ST_WR_REQ) && !w_done_q;
  assign o_wdata  = wdata_rep;
  assign o_wstrb  = o_wvalid ? strb : 4'h0;
  assign o_wlast  = 1'b1;
  assign o_bready = (state_q == ST_WR_RESP);

  assign limp.ready  = (state_q == ST_DONE);
  assign o_bus_error = (state_q == ST_DONE) && resp_q[1];

  // Caller alignment and single-beat response checks
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (accept)
        assert (!misaligned(limp.size, limp.addr[1:0]))
          else $error("misaligned LIMP request %h", limp.addr);
      if (i_rvalid && o_rready)
        assert (i_rlast && (i_rid == ID))
          else $error("bad R beat: rlast %b rid %h", i_rlast, i_rid);
      if (i_bvalid && o_bready)
        assert (i_bid == ID)
          else $error("bad B id %h", i_bid);
    end
  end

endmodule
